uart_rx_sequencer: RTL

Frame-level controller for the UART receive path. It generates its own oversampling tick from a programmable divisor and detects and qualifies the start bit. It samples the data bits mid-bit into an internal shift register, checks the stop bit, and hands each completed byte to a consumer through a valid/accept holding register. It sits between the input filter output (RXD) and the host-side byte interface, replacing free-running bit sampling with a sequenced, overrun-aware receiver.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_tick_gen.sv | 28 ++
 rtl/uart_rx_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sequencer.
// Holds the FSM state encoding, default frame geometry and the start-sample point helper.
package uart_rx_pkg;

   localparam int UART_SIZE       = 8;
   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK_WAIT
   } state_t;

   // Tick index within the start bit at which the line is re-checked (mid start bit).
   function automatic int start_sample_pt(input int os);
      return os / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: down-counter that pulses o_tick for one cycle at zero and reloads
// with max(i_div,1)-1. The divisor is sampled only at reload; a divisor of 0 or 1 gives a tick every cycle.
module uart_rx_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_reload;

   assign w_reload = (i_div == '0) ? '0 : i_div - DIV_W'(1);
   assign o_tick   = (r_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (r_cnt == '0) begin
         r_cnt <= w_reload;
      end else begin
         r_cnt <= r_cnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART frame receiver: start qualification, mid-bit sampling, stop check and a valid/accept holding
// register with sticky overrun; ~(OS/2+(SIZE+1)*OS)*BAUD_DIV cycles latency. Parity via UART_RX_PARITY_EN.
module uart_rx_sequencer
   import uart_rx_pkg::*;
#(
   parameter int SIZE       = UART_SIZE,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DIV_W      = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [DIV_W-1:0] BAUD_DIV,
   input  logic             RXD,
   input  logic             RX_ACCEPT,
`ifdef UART_RX_PARITY_EN
   input  logic             PARITY_ODD,
   output logic             PARITY_ERROR,
`endif
   output logic [SIZE-1:0]  DQ,
   output logic             RX_VALID,
   output logic             FRAME_ERROR,
   output logic             OVERRUN,
   output logic             BUSY
);

   localparam int SC_W = $clog2(OVERSAMPLE);
   localparam int BC_W = $clog2(SIZE + 1);
   localparam logic [SC_W-1:0] START_PT = SC_W'(start_sample_pt(OVERSAMPLE));
   localparam logic [SC_W-1:0] LAST_PT  = SC_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SIZE - 1);

   logic            w_tick;
   logic            w_complete;
   logic            w_free;
   state_t          r_state;
   logic [SC_W-1:0] r_sample_cnt;
   logic [BC_W-1:0] r_bit_cnt;
   logic [SIZE-1:0] r_shift;
   logic            r_busy;
   logic [SIZE-1:0] r_dq;
   logic            r_valid;
   logic            r_ferr;
   logic            r_ovr;

   uart_rx_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_div  (BAUD_DIV),
      .o_tick (w_tick)
   );

   // The frame completes on the stop-sample tick; the holding register updates on the same edge.
   assign w_complete = w_tick && (r_state == STOP) && (r_sample_cnt == LAST_PT);
   assign w_free     = !r_valid || RX_ACCEPT;

`ifdef UART_RX_PARITY_EN
   logic r_par_bit;
   logic r_perr;
   logic w_perr;

   assign w_perr       = (^r_shift) ^ r_par_bit ^ PARITY_ODD;
   assign PARITY_ERROR = r_perr;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= IDLE;
         r_sample_cnt <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
`endif
      end else if (w_tick) begin
         unique case (r_state)
            IDLE: begin
               if (!RXD) begin
                  r_state      <= START;
                  r_sample_cnt <= '0;
                  r_busy       <= 1'b1;
               end
            end
            START: begin
               if (r_sample_cnt == START_PT) begin
                  r_sample_cnt <= '0;
                  r_bit_cnt    <= '0;
                  if (!RXD) begin
                     r_state <= DATA;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_sample_cnt <= r_sample_cnt + SC_W'(1);
               end
            end
            DATA: begin
               if (r_sample_cnt == LAST_PT) begin
                  r_sample_cnt <= '0;
                  r_shift      <= {RXD, r_shift[SIZE-1:1]};
                  r_bit_cnt    <= r_bit_cnt + BC_W'(1);
                  if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end
               end else begin
                  r_sample_cnt <= r_sample_cnt + SC_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (r_sample_cnt == LAST_PT) begin
                  r_sample_cnt <= '0;
                  r_par_bit    <= RXD;
                  r_state      <= STOP;
               end else begin
                  r_sample_cnt <= r_sample_cnt + SC_W'(1);
               end
            end
`endif
            STOP: begin
               if (r_sample_cnt == LAST_PT) begin
                  r_sample_cnt <= '0;
                  if (RXD) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= BRK_WAIT;
                  end
               end else begin
                  r_sample_cnt <= r_sample_cnt + SC_W'(1);
               end
            end
            // A line still low after a bad stop must return high before a new start counts.
            BRK_WAIT: begin
               if (RXD) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_dq    <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr  <= 1'b0;
`endif
      end else if (w_complete && w_free) begin
         r_dq    <= r_shift;
         r_ferr  <= !RXD;
         r_valid <= 1'b1;
         r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr  <= w_perr;
`endif
      end else if (w_complete) begin
         r_ovr <= 1'b1;
      end else if (r_valid && RX_ACCEPT) begin
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end
   end

   assign DQ          = r_dq;
   assign RX_VALID    = r_valid;
   assign FRAME_ERROR = r_ferr;
   assign OVERRUN     = r_ovr;
   assign BUSY        = r_busy;

endmodule
